serial_adder: RTL

Bit-serial unsigned adder: accepts two WIDTH-bit operands on a start pulse and adds them LSB-first, one bit per clock, through a single full-adder cell. It returns the WIDTH-bit sum plus carry-out with a one-cycle done strobe. It is the additive counterpart of the team's subtractor cells. It serves as the area-minimal arithmetic primitive for datapaths where latency is cheap and gates are not.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/full_adder.sv | 22 ++
 rtl/serial_adder.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encodings and the
//   default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single combinational full-adder cell; the only arithmetic gate in the
//   bit-serial adder.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. Operands are captured on an accepted start and
//   added LSB-first, one bit per clock, through one full_adder cell. After
//   WIDTH RUN cycles the sum and carry-out are registered and done strobes for
//   one cycle.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : synchronous active-low reset
//     start  : request to begin an addition (ignored while busy)
//     a, b   : operands, sampled only on the accepting edge
//     busy   : high while the addition is running
//     done   : one-cycle strobe, result valid from this cycle on
//     sum    : a + b mod 2^WIDTH, held until the next completion
//     cout   : carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            // The edge closing the DONE cycle also acts as the first IDLE
            // edge, so a held start restarts every WIDTH+1 cycles with busy
            // dropping only for the DONE cycle.
            IDLE, DONE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               // Sum bits enter at the MSB so after WIDTH shifts bit 0 of
               // the operands has reached bit 0 of acc.
               acc   <= {fa_s, acc[WIDTH-1:1]};
               carry <= fa_c;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) begin
                  sum   <= {fa_s, acc[WIDTH-1:1]};
                  cout  <= fa_c;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule : serial_adder
